vector_line_engine: RTL
=======================

Name: vector_line_engine

Overview:
- Command responder and beam generator for the vector display path.
- Accepts absolute 12-bit target points from the command sequencer over a draw/jump/ready handshake.
- Draws: walks the beam from the current position to the target with Bresenham steps, beam on.
- Jumps: moves the beam to the target in one step, beam off, then waits a settle period.
- Its outputs feed the X/Y DAC and Z (blank) drivers.

Parameters:
- COORD_W, 12, coordinate width for x/y inputs and beam outputs.
- STEP_DIV, 1, clocks per Bresenham step (beam dwell per point), range 1..65535.
- JUMP_SETTLE, 16, clocks of blanked settle after a jump, range 1..65535.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- x  in  COORD_W  target X; sampled only when a command is accepted.
- y  in  COORD_W  target Y; sampled only when a command is accepted.
- draw  in  1  single-cycle pulse: draw a line to (x,y), beam on.
- jump  in  1  single-cycle pulse: move to (x,y), beam off.
- ready  out  1  high when idle and able to accept a command.
- x_out  out  COORD_W  current beam X to DAC.
- y_out  out  COORD_W  current beam Y to DAC.
- z_out  out  1  beam enable; 1 = visible.

Behaviour:
- Reset (asserted low, async): state=IDLE, x_out=0, y_out=0, z_out=0, ready=1, step/settle counters=0. Reset mid-line aborts immediately. After release, the first accepted command starts from (0,0).
- Accept rule: command accepted on a rising edge where ready=1 and (draw|jump)=1; x,y latched on that edge.
- Draw and jump high together: jump wins, draw dropped.
- Pulses while ready=0 are ignored, not queued.
- ready goes 0 on the edge after acceptance. No combinational path from draw/jump to ready.
- States: IDLE, SETUP, DRAW, SETTLE.
- IDLE: ready=1, z_out=0. draw -> SETUP. jump -> SETTLE.
- jump, on the accept edge: x_out,y_out <= target; z_out=0; settle counter loaded with JUMP_SETTLE-1. Next state SETTLE.
- SETTLE: counter decrements each clock. At 0 -> IDLE with ready=1. A jump is therefore busy for exactly JUMP_SETTLE cycles.
- SETUP (1 cycle): compute
  - dx = |tx - x_out|, dy = -|ty - y_out|
  - sx/sy = +1 or -1 (+1 when equal)
  - err = dx + dy
  - Widths: deltas COORD_W+1 signed; err and e2 COORD_W+3 signed. No overflow anywhere in 0..4095 space.
  - Next state DRAW, z_out <= 1.
- DRAW: z_out=1. The step counter counts STEP_DIV clocks per point. At the end of each dwell:
  - If (x_out,y_out)==target: go to IDLE, z_out <= 0, ready <= 1.
  - Else, with e2 = 2*err:
    - if e2 >= dy: err += dy, x_out += sx
    - if e2 <= dx: err += dx, y_out += sy
    - Both may apply in one step (diagonal).
- Point count for a draw: max(|dx|,|dy|)+1, including start and endpoint. Each point is lit for STEP_DIV clocks.
- Draw busy time: 1 (SETUP) + STEP_DIV*(max(|dx|,|dy|)+1) clocks.
- Zero-length draw (target == current): endpoint lit for one dwell, then IDLE.
- x_out/y_out never leave the bounding box of start and target; no wrap-around.
- Outputs hold their last value in IDLE. The beam stays at the last point, blanked.

Decomposition:
- Shared package vector_pkg:
  - COORD_W default constant.
  - state enum {IDLE, SETUP, DRAW, SETTLE}.
  - coord_t typedef (unsigned COORD_W).
  - err_t typedef (signed COORD_W+3).
- One natural sub-module, bresenham_step: combinational next-point/next-err function of (pos, err, dx, dy, sx, sy). Reused by a future circle/arc engine.
- The counters and FSM stay in vector_line_engine.

Test Plan:
- Reset then idle: reset low for 3 cycles, release -> ready=1, x_out=0, y_out=0, z_out=0. Reset during a DRAW of (0,0)->(100,0) -> outputs return to 0 and ready to 1 asynchronously.
- Horizontal draw, STEP_DIV=1, from (0,0): pulse draw with x=3,y=0 at edge T.
  - ready=0 from T+1.
  - z_out=1 with x_out=0,1,2,3 on cycles T+2..T+5.
  - ready=1 and z_out=0 at T+6.
- Steep diagonal, STEP_DIV=2, from (10,10) to (7,20):
  - 11 points, each held 2 cycles.
  - Final (7,20); y strictly increments each point; x non-increasing.
  - Every point matches a reference Bresenham model.
- Jump with JUMP_SETTLE=16: pulse jump to (4095,4095) -> x_out=y_out=4095 on the next edge, z_out=0 throughout, ready low for exactly 16 cycles.
- Simultaneous and busy commands:
  - draw and jump in the same cycle -> jump behaviour, no beam-on.
  - draw pulse during SETTLE -> ignored; position unchanged after settle.
- Zero-length and corner extremes:
  - draw to the current point -> one lit dwell.
  - draw (0,0)->(4095,0)->(0,4095) -> 4096 points each, no overflow; err stays within err_t range (assertion).

Source files
------------

// File: rtl/vector_pkg.sv
// -----------------------------------------------------------------------------
// vector_pkg
// Shared types and constants for the vector display beam path.
//   DEFAULT_COORD_W : default coordinate width (12-bit DAC space, 0..4095)
//   state_t         : line engine FSM states
//   coord_t         : unsigned beam/target coordinate at the default width
//   delta_t         : signed per-axis delta (one extra bit for the sign)
//   err_t           : signed Bresenham error term; two bits wider than the
//                     deltas so that both err + dx + dy and 2*err fit
// -----------------------------------------------------------------------------
package vector_pkg;

   localparam int DEFAULT_COORD_W = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      DRAW   = 2'd2,
      SETTLE = 2'd3
   } state_t;

   typedef logic        [DEFAULT_COORD_W-1:0] coord_t;
   typedef logic signed [DEFAULT_COORD_W:0]   delta_t;
   typedef logic signed [DEFAULT_COORD_W+2:0] err_t;

endpackage

// File: rtl/bresenham_step.sv
// -----------------------------------------------------------------------------
// bresenham_step
// Combinational single step of the integer Bresenham walk. Given the current
// point, the running error and the (constant) deltas/directions of the line,
// produces the next point and the updated error. Holds no state, so it can be
// shared by other curve walkers.
// Ports:
//   x, y           : current point
//   err            : current error term
//   dx             : |tx - x0|, non-negative
//   dy             : -|ty - y0|, non-positive
//   sx_neg, sy_neg : 1 = step towards smaller coordinates on that axis
//   x_next, y_next : next point
//   err_next       : error term after the step
// -----------------------------------------------------------------------------
module bresenham_step
   import vector_pkg::*;
#(
   parameter int COORD_W = DEFAULT_COORD_W
) (
   input  logic        [COORD_W-1:0] x,
   input  logic        [COORD_W-1:0] y,
   input  logic signed [COORD_W+2:0] err,
   input  logic signed [COORD_W:0]   dx,
   input  logic signed [COORD_W:0]   dy,
   input  logic                      sx_neg,
   input  logic                      sy_neg,
   output logic        [COORD_W-1:0] x_next,
   output logic        [COORD_W-1:0] y_next,
   output logic signed [COORD_W+2:0] err_next
);

   logic signed [COORD_W+2:0] dx_ext;
   logic signed [COORD_W+2:0] dy_ext;
   logic signed [COORD_W+2:0] e2;
   logic                      step_x;
   logic                      step_y;

   always_comb begin
      dx_ext   = {{2{dx[COORD_W]}}, dx};
      dy_ext   = {{2{dy[COORD_W]}}, dy};
      e2       = err <<< 1;
      // Both tests use the pre-step e2, so a diagonal move applies both.
      step_x   = (e2 >= dy_ext);
      step_y   = (e2 <= dx_ext);
      err_next = err;
      x_next   = x;
      y_next   = y;
      if (step_x) begin
         err_next = err_next + dy_ext;
         x_next   = sx_neg ? (x - COORD_W'(1)) : (x + COORD_W'(1));
      end
      if (step_y) begin
         err_next = err_next + dx_ext;
         y_next   = sy_neg ? (y - COORD_W'(1)) : (y + COORD_W'(1));
      end
   end

endmodule

// File: rtl/vector_line_engine.sv
// -----------------------------------------------------------------------------
// vector_line_engine
// Command responder and beam generator for the vector display. Accepts
// absolute target points with a draw/jump pulse while ready is high.
//   draw : walk the beam to the target with Bresenham steps, beam on, each
//          point held for STEP_DIV clocks.
//   jump : move the beam to the target in one clock, beam off, then wait
//          JUMP_SETTLE clocks (blanked) for the deflection to settle.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low
//   x, y         : target point, sampled on the accept edge
//   draw, jump   : single-cycle command pulses (jump wins if both)
//   ready        : idle and able to accept a command
//   x_out, y_out : current beam position to the X/Y DACs
//   z_out        : beam enable, 1 = visible
// -----------------------------------------------------------------------------
module vector_line_engine
   import vector_pkg::*;
#(
   parameter int COORD_W     = DEFAULT_COORD_W,
   parameter int STEP_DIV    = 1,
   parameter int JUMP_SETTLE = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               draw,
   input  logic               jump,
   output logic               ready,
   output logic [COORD_W-1:0] x_out,
   output logic [COORD_W-1:0] y_out,
   output logic               z_out
);

   localparam logic [15:0] STEP_LOAD   = 16'(STEP_DIV - 1);
   localparam logic [15:0] SETTLE_LOAD = 16'(JUMP_SETTLE - 1);

   state_t                    state_reg,      state_next;
   logic        [COORD_W-1:0] x_reg,          x_next;
   logic        [COORD_W-1:0] y_reg,          y_next;
   logic                      z_reg,          z_next;
   logic        [COORD_W-1:0] tx_reg,         tx_next;
   logic        [COORD_W-1:0] ty_reg,         ty_next;
   logic signed [COORD_W:0]   dx_reg,         dx_next;
   logic signed [COORD_W:0]   dy_reg,         dy_next;
   logic                      sx_neg_reg,     sx_neg_next;
   logic                      sy_neg_reg,     sy_neg_next;
   logic signed [COORD_W+2:0] err_reg,        err_next;
   logic        [15:0]        step_cnt_reg,   step_cnt_next;
   logic        [15:0]        settle_cnt_reg, settle_cnt_next;

   logic        [COORD_W-1:0] adx;
   logic        [COORD_W-1:0] ady;
   logic        [COORD_W-1:0] bx;
   logic        [COORD_W-1:0] by;
   logic signed [COORD_W+2:0] berr;

   bresenham_step #(
      .COORD_W (COORD_W)
   ) u_step (
      .x        (x_reg),
      .y        (y_reg),
      .err      (err_reg),
      .dx       (dx_reg),
      .dy       (dy_reg),
      .sx_neg   (sx_neg_reg),
      .sy_neg   (sy_neg_reg),
      .x_next   (bx),
      .y_next   (by),
      .err_next (berr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         x_reg          <= '0;
         y_reg          <= '0;
         z_reg          <= 1'b0;
         tx_reg         <= '0;
         ty_reg         <= '0;
         dx_reg         <= '0;
         dy_reg         <= '0;
         sx_neg_reg     <= 1'b0;
         sy_neg_reg     <= 1'b0;
         err_reg        <= '0;
         step_cnt_reg   <= '0;
         settle_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         x_reg          <= x_next;
         y_reg          <= y_next;
         z_reg          <= z_next;
         tx_reg         <= tx_next;
         ty_reg         <= ty_next;
         dx_reg         <= dx_next;
         dy_reg         <= dy_next;
         sx_neg_reg     <= sx_neg_next;
         sy_neg_reg     <= sy_neg_next;
         err_reg        <= err_next;
         step_cnt_reg   <= step_cnt_next;
         settle_cnt_reg <= settle_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      x_next          = x_reg;
      y_next          = y_reg;
      z_next          = z_reg;
      tx_next         = tx_reg;
      ty_next         = ty_reg;
      dx_next         = dx_reg;
      dy_next         = dy_reg;
      sx_neg_next     = sx_neg_reg;
      sy_neg_next     = sy_neg_reg;
      err_next        = err_reg;
      step_cnt_next   = step_cnt_reg;
      settle_cnt_next = settle_cnt_reg;
      adx             = '0;
      ady             = '0;

      case (state_reg)
         IDLE: begin
            if (jump) begin
               // Jump moves the beam on the accept edge itself.
               x_next          = x;
               y_next          = y;
               z_next          = 1'b0;
               settle_cnt_next = SETTLE_LOAD;
               state_next      = SETTLE;
            end else if (draw) begin
               tx_next    = x;
               ty_next    = y;
               state_next = SETUP;
            end
         end

         SETUP: begin
            adx         = (tx_reg >= x_reg) ? (tx_reg - x_reg) : (x_reg - tx_reg);
            ady         = (ty_reg >= y_reg) ? (ty_reg - y_reg) : (y_reg - ty_reg);
            dx_next     = $signed({1'b0, adx});
            dy_next     = -$signed({1'b0, ady});
            sx_neg_next = (tx_reg < x_reg);
            sy_neg_next = (ty_reg < y_reg);
            err_next    = {{2{dx_next[COORD_W]}}, dx_next}
                        + {{2{dy_next[COORD_W]}}, dy_next};
            step_cnt_next = STEP_LOAD;
            z_next        = 1'b1;
            state_next    = DRAW;
         end

         DRAW: begin
            if (step_cnt_reg != '0) begin
               step_cnt_next = step_cnt_reg - 16'd1;
            end else if ((x_reg == tx_reg) && (y_reg == ty_reg)) begin
               // Endpoint has had its dwell: blank and hold position.
               z_next     = 1'b0;
               state_next = IDLE;
            end else begin
               x_next        = bx;
               y_next        = by;
               err_next      = berr;
               step_cnt_next = STEP_LOAD;
            end
         end

         SETTLE: begin
            if (settle_cnt_reg == '0) begin
               state_next = IDLE;
            end else begin
               settle_cnt_next = settle_cnt_reg - 16'd1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Decoded from the state register only, so draw/jump never reach ready
   // combinationally.
   assign ready = (state_reg == IDLE);
   assign x_out = x_reg;
   assign y_out = y_reg;
   assign z_out = z_reg;

   // Doubling err inside the step must never overflow: the top two bits of
   // err have to agree.
   err_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      err_reg[COORD_W+2] == err_reg[COORD_W+1]);

endmodule
